gon_xbus_scheduler: RTL
=======================

GON_XBUS_SCHEDULER -- requirements
Module: gon_xbus_scheduler

Interface
REQ-001 SHALL have parameter MASTER_NUMS, default 14, number of multicast controllers on the X-bus (legal range 2..32).
REQ-002 SHALL have parameter ID_LEN, default 5, width of IDs and tags.
REQ-003 SHALL have parameter VALUE_LEN, default 32, width of the data payload.
REQ-004 SHALL have parameter MAX_RETRY, default 4, number of bus polls before a miss is reported (legal range 1..255).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port cfg_start, input, 1, pulse that starts an ID load.
REQ-008 SHALL have ports cfg_id, cfg_id_valid and cfg_id_ready: input ID_LEN, input 1 and output 1, the ID stream.
REQ-009 SHALL have ports set_id, output 1, and id_scan_out, output ID_LEN: scan-chain shift enable and bus chain input.
REQ-010 SHALL have port id_scan_ret, input, ID_LEN, bus chain output (last stage).
REQ-011 SHALL have ports cfg_ok and cfg_err, outputs, 1 each: sticky configuration status.
REQ-012 SHALL have ports req_tag, req_valid and req_ready: input ID_LEN, input 1 and output 1, the read request.
REQ-013 SHALL have port ready_tag, output, ID_LEN+1: {ready, tag} to the bus.
REQ-014 SHALL have port enable_value, input, VALUE_LEN+1: {enable, value} from the bus.
REQ-015 SHALL have ports out_valid, out_tag, out_value, out_miss and out_ready: outputs 1, ID_LEN, VALUE_LEN and 1, plus input 1, the result slot.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, VERIFY and ISSUE.
REQ-018 SHALL, in IDLE, go to LOAD on cfg_start; at the same time clear cfg_ok and cfg_err and set the shift counter to 0.
REQ-019 SHALL give cfg_start priority over req_valid in the same cycle, and ignore cfg_start outside IDLE.
REQ-020 SHALL hold cfg_id_ready=1 only in LOAD.
REQ-021 SHALL, in LOAD, on each cycle with cfg_id_valid=1:
- set set_id=1 for that cycle;
- drive id_scan_out=cfg_id;
- increment the counter.
REQ-022 SHALL, in LOAD, hold set_id=0 and id_scan_out=0 on cycles without cfg_id_valid.
REQ-023 SHALL latch the first accepted ID as first_id.
REQ-024 SHALL go to VERIFY after the MASTER_NUMS-th accepted ID.
REQ-025 SHALL, in VERIFY (1 cycle), set cfg_ok=1 if id_scan_ret==first_id, else cfg_err=1, then return to IDLE.
REQ-026 SHALL drive req_ready=1 only in IDLE with cfg_ok=1, cfg_start=0, and (out_valid=0 or out_ready=1).
REQ-027 SHALL, on request accept, latch req_tag, clear the retry counter and enter ISSUE.
REQ-028 SHALL, in ISSUE, drive ready_tag={1,tag}; in all other states ready_tag=0.
REQ-029 SHALL sample enable_value in the same cycle as ready is driven (the bus responds combinationally).
REQ-030 SHALL, in ISSUE with enable=1, load out_valid=1, out_tag=tag, out_value=value and out_miss=0, then go to IDLE.
REQ-031 SHALL, in ISSUE with enable=0, increment the retry counter.
REQ-032 SHALL, when the MAX_RETRY-th poll fails, load out_valid=1, out_value=0 and out_miss=1, then go to IDLE; ISSUE lasts at most MAX_RETRY cycles.
REQ-033 SHALL clear out_valid on out_valid&&out_ready unless the slot is reloaded in the same cycle; the load wins.
REQ-034 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-035 SHALL, on rst=0 at a clock edge, force:
- state=IDLE;
- counters, first_id and tag to 0;
- cfg_ok=0, cfg_err=0, out_valid=0, out_miss=0, out_tag=0, out_value=0;
- set_id=0, ready_tag=0.
REQ-036 SHALL allow reset mid-LOAD or mid-ISSUE to abort cleanly, without a result being emitted and with cfg_ok=0.

Verification
REQ-037 SHALL cover: MASTER_NUMS=14, cfg_start, IDs 1..14 with valid always high, id_scan_ret=1 in VERIFY -> set_id high exactly 14 cycles, cfg_ok=1 on the 16th cycle after cfg_start, cfg_err=0.
REQ-038 SHALL cover: same load with id_scan_ret=7 -> cfg_err=1, cfg_ok=0, req_ready stays 0.
REQ-039 SHALL cover: configured; req_tag=3; bus enable=1, value=0xDEADBEEF in the first ISSUE cycle -> ready_tag=0x23 for 1 cycle, next cycle out_valid=1, out_tag=3, out_value=0xDEADBEEF, out_miss=0.
REQ-040 SHALL cover: configured; enable held 0 with MAX_RETRY=4 -> ready asserted 4 cycles, then out_valid=1, out_miss=1, out_value=0.
REQ-041 SHALL cover: out_ready=0 with a result pending and req_valid=1 -> req_ready=0 and out_* stable; raising out_ready -> same-cycle accept of the next request.
REQ-042 SHALL cover: rst=0 after the 5th ID of a load -> all outputs at reset values next cycle; a fresh load of 14 IDs then succeeds.

Source files
------------

// File: rtl/gon_xbus_scheduler.sv
// X-bus scheduler: loads the multicast controller ID chain, verifies it by loop-back,
// then polls the bus for tagged read requests and presents hits/misses in a result slot.
module gon_xbus_scheduler #(
  parameter int MASTER_NUMS = 14,
  parameter int ID_LEN      = 5,
  parameter int VALUE_LEN   = 32,
  parameter int MAX_RETRY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [ID_LEN-1:0]    cfg_id,
  input  logic                 cfg_id_valid,
  output logic                 cfg_id_ready,
  output logic                 set_id,
  output logic [ID_LEN-1:0]    id_scan_out,
  input  logic [ID_LEN-1:0]    id_scan_ret,
  output logic                 cfg_ok,
  output logic                 cfg_err,
  input  logic [ID_LEN-1:0]    req_tag,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [ID_LEN:0]      ready_tag,
  input  logic [VALUE_LEN:0]   enable_value,
  output logic                 out_valid,
  output logic [ID_LEN-1:0]    out_tag,
  output logic [VALUE_LEN-1:0] out_value,
  output logic                 out_miss,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int               CNT_W     = $clog2(MASTER_NUMS + 1);
  localparam logic [CNT_W-1:0] LAST_ID   = CNT_W'(MASTER_NUMS - 1);
  localparam logic [7:0]       LAST_POLL = 8'(MAX_RETRY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, ISSUE} state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]     id_cnt;
  logic [7:0]           retry_cnt;
  logic [ID_LEN-1:0]    first_id;
  logic [ID_LEN-1:0]    tag;

  logic                 bus_enable;
  logic [VALUE_LEN-1:0] bus_value;
  logic                 last_poll;

  logic                 start_load;
  logic                 id_accept;
  logic                 verify_done;
  logic                 req_accept;
  logic                 result_load;
  logic                 result_miss;

  assign bus_enable = enable_value[VALUE_LEN];
  assign bus_value  = enable_value[VALUE_LEN-1:0];
  assign last_poll  = (retry_cnt == LAST_POLL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cfg_id_ready = 1'b0;
    set_id       = 1'b0;
    id_scan_out  = '0;
    req_ready    = 1'b0;
    ready_tag    = '0;
    start_load   = 1'b0;
    id_accept    = 1'b0;
    verify_done  = 1'b0;
    req_accept   = 1'b0;
    result_load  = 1'b0;
    result_miss  = 1'b0;

    case (state)
      IDLE: begin
        // A pending result must be drained (or be drained this cycle) before a new request.
        req_ready = cfg_ok && !cfg_start && (!out_valid || out_ready);
        if (cfg_start) begin
          start_load = 1'b1;
          state_next = LOAD;
        end else if (req_valid && req_ready) begin
          req_accept = 1'b1;
          state_next = ISSUE;
        end
      end

      LOAD: begin
        cfg_id_ready = 1'b1;
        if (cfg_id_valid) begin
          id_accept   = 1'b1;
          set_id      = 1'b1;
          id_scan_out = cfg_id;
          if (id_cnt == LAST_ID) begin
            state_next = VERIFY;
          end
        end
      end

      VERIFY: begin
        verify_done = 1'b1;
        state_next  = IDLE;
      end

      ISSUE: begin
        ready_tag = {1'b1, tag};
        if (bus_enable) begin
          result_load = 1'b1;
          state_next  = IDLE;
        end else if (last_poll) begin
          result_load = 1'b1;
          result_miss = 1'b1;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_cnt   <= '0;
      first_id <= '0;
      cfg_ok   <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (start_load) begin
        id_cnt  <= '0;
        cfg_ok  <= 1'b0;
        cfg_err <= 1'b0;
      end else if (id_accept) begin
        id_cnt <= id_cnt + 1'b1;
        if (id_cnt == '0) begin
          first_id <= cfg_id;
        end
      end
      // The first ID has travelled the whole chain and should now sit in the last stage.
      if (verify_done) begin
        if (id_scan_ret == first_id) begin
          cfg_ok <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag       <= '0;
      retry_cnt <= '0;
    end else begin
      if (req_accept) begin
        tag       <= req_tag;
        retry_cnt <= '0;
      end else if (state == ISSUE && !bus_enable) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_value <= '0;
      out_miss  <= 1'b0;
    end else begin
      if (result_load) begin
        out_valid <= 1'b1;
        out_tag   <= tag;
        out_value <= result_miss ? '0 : bus_value;
        out_miss  <= result_miss;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
